a2d_sweep_intf: RTL and testbench

- Parametrised successor to the single-channel A2D SPI interface in the Digital_Core.
- One `nxt` pulse starts an automatic sweep of `NUM_CH` channels on the ADC128S-style SPI A2D, which supplies the load cells and battery measurements.
- Channel commands are pipelined: each transaction sends the next channel's address while reading back the previous channel's result.
- Per-channel results are optionally IIR-filtered and presented as one flat bus to balance/steer logic.

---
 rtl/a2d_sweep_intf.sv | 182 ++++++++++++++++++
 tb/tb_a2d_sweep_intf.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/a2d_sweep_intf.sv
// Multi-channel sweep controller for an ADC128S-style SPI A2D. Each transaction addresses the
// next channel while reading back the previous one; results are optionally IIR-filtered.
module a2d_sweep_intf #(
    parameter int unsigned         NUM_CH    = 3,
    parameter logic [3*NUM_CH-1:0] CH_MAP    = {3'd5, 3'd4, 3'd0},
    parameter int unsigned         SCLK_DIV  = 32,
    parameter int unsigned         AVG_SHIFT = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 nxt,
    input  logic                 MISO,
    output logic                 SS_n,
    output logic                 SCLK,
    output logic                 MOSI,
    output logic [12*NUM_CH-1:0] results,
    output logic                 busy,
    output logic                 sweep_done
);

    localparam int unsigned Half = SCLK_DIV / 2;
    localparam int unsigned CntW = $clog2(SCLK_DIV);
    localparam int unsigned TxnW = $clog2(NUM_CH + 1);

    typedef enum logic [2:0] {StIdle, StFront, StShift, StBack, StGap, StDone} state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [3:0]        bit_q, bit_d;
    logic [TxnW-1:0]   txn_q, txn_d;
    logic [15:0]       tx_q, tx_d;
    logic [11:0]       rx_q, rx_d;
    logic              ss_n_q, ss_n_d;
    logic              sclk_q, sclk_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              primed_q, primed_d;
    logic [11:0]       slot_q [NUM_CH];
    logic [11:0]       slot_d [NUM_CH];

    logic [TxnW-1:0]   slot_idx;
    logic [11:0]       old_val, new_val;
    logic signed [12:0] diff, step;

    // The final transaction repeats the last channel's address; its reply is the last slot.
    function automatic logic [15:0] cmd_for(input logic [TxnW-1:0] t);
        int unsigned idx;
        idx = 32'(t);
        if (idx >= NUM_CH) idx = NUM_CH - 1;
        return {2'b00, CH_MAP[3*idx +: 3], 11'h000};
    endfunction

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q + 1'b1;
        bit_d    = bit_q;
        txn_d    = txn_q;
        tx_d     = tx_q;
        rx_d     = rx_q;
        ss_n_d   = ss_n_q;
        sclk_d   = sclk_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        primed_d = primed_q;
        slot_d   = slot_q;

        slot_idx = txn_q - 1'b1;
        old_val  = slot_q[slot_idx];
        diff     = $signed({1'b0, rx_q}) - $signed({1'b0, old_val});
        step     = diff >>> AVG_SHIFT;
        new_val  = (AVG_SHIFT == 0 || !primed_q) ? rx_q : old_val + step[11:0];

        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (nxt) begin
                    state_d = StFront;
                    busy_d  = 1'b1;
                    ss_n_d  = 1'b0;
                    txn_d   = '0;
                    tx_d    = cmd_for('0);
                end
            end
            StFront: begin
                if (cnt_q == CntW'(Half - 1)) begin
                    state_d = StShift;
                    cnt_d   = '0;
                    bit_d   = '0;
                    sclk_d  = 1'b0;
                end
            end
            StShift: begin
                if (cnt_q == CntW'(Half - 1)) sclk_d = 1'b1;
                // MISO is taken one clk after the rising edge
                if (cnt_q == CntW'(Half)) rx_d = {rx_q[10:0], MISO};
                if (cnt_q == CntW'(SCLK_DIV - 1)) begin
                    cnt_d = '0;
                    if (bit_q == 4'd15) begin
                        state_d = StBack;
                    end else begin
                        bit_d  = bit_q + 1'b1;
                        sclk_d = 1'b0;
                        tx_d   = {tx_q[14:0], 1'b0};
                    end
                end
            end
            StBack: begin
                if (cnt_q == CntW'(Half - 1)) begin
                    state_d = StGap;
                    cnt_d   = '0;
                    ss_n_d  = 1'b1;
                    tx_d    = '0;
                    if (txn_q != '0) slot_d[slot_idx] = new_val;
                end
            end
            StGap: begin
                if (cnt_q == CntW'(Half - 1)) begin
                    cnt_d = '0;
                    if (txn_q == TxnW'(NUM_CH)) begin
                        state_d  = StDone;
                        done_d   = 1'b1;
                        busy_d   = 1'b0;
                        primed_d = 1'b1;
                    end else begin
                        state_d = StFront;
                        txn_d   = txn_q + 1'b1;
                        ss_n_d  = 1'b0;
                        tx_d    = cmd_for(txn_q + 1'b1);
                    end
                end
            end
            StDone: begin
                cnt_d   = '0;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            bit_q    <= '0;
            txn_q    <= '0;
            tx_q     <= '0;
            rx_q     <= '0;
            ss_n_q   <= 1'b1;
            sclk_q   <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            primed_q <= 1'b0;
            slot_q   <= '{default: '0};
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
            txn_q    <= txn_d;
            tx_q     <= tx_d;
            rx_q     <= rx_d;
            ss_n_q   <= ss_n_d;
            sclk_q   <= sclk_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            primed_q <= primed_d;
            slot_q   <= slot_d;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : gen_results
        assign results[12*i +: 12] = slot_q[i];
    end

    assign SS_n       = ss_n_q;
    assign SCLK       = sclk_q;
    assign MOSI       = tx_q[15];
    assign busy       = busy_q;
    assign sweep_done = done_q;

endmodule

// File: tb/tb_a2d_sweep_intf.sv
// Bench for a2d_sweep_intf: two configurations, each driven by an A2D bus model, with results
// checked against a per-slot reference model of the sweep/filter rules.
module tb_a2d_sweep_intf;

    localparam int NumA = 3;
    localparam int NumB = 8;
    localparam int DivA = 32;
    localparam int DivB = 4;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [1:0]         nxt, miso, ss_n, sclk, mosi, busy, done;
    logic [12*NumA-1:0] res_a;
    logic [12*NumB-1:0] res_b;
    logic [11:0]        adc_val [2][8];

    int vecs = 0;
    int errs = 0;
    int exp_res [2][8];
    bit primed [2];

    always #5 clk = ~clk;

    a2d_sweep_intf #(
        .NUM_CH   (NumA),
        .CH_MAP   ({3'd5, 3'd4, 3'd0}),
        .SCLK_DIV (DivA),
        .AVG_SHIFT(2)
    ) u_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .nxt       (nxt[0]),
        .MISO      (miso[0]),
        .SS_n      (ss_n[0]),
        .SCLK      (sclk[0]),
        .MOSI      (mosi[0]),
        .results   (res_a),
        .busy      (busy[0]),
        .sweep_done(done[0])
    );

    a2d_sweep_intf #(
        .NUM_CH   (NumB),
        .CH_MAP   ({3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0}),
        .SCLK_DIV (DivB),
        .AVG_SHIFT(0)
    ) u_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .nxt       (nxt[1]),
        .MISO      (miso[1]),
        .SS_n      (ss_n[1]),
        .SCLK      (sclk[1]),
        .MOSI      (mosi[1]),
        .results   (res_b),
        .busy      (busy[1]),
        .sweep_done(done[1])
    );

    // A2D bus model: replies with the conversion of the channel addressed in the previous frame.
    for (genvar g = 0; g < 2; g++) begin : gen_m
        logic [15:0] word   = '0;
        logic [15:0] rxw    = '0;
        logic        miso_r = 1'b0;
        logic [2:0]  last_addr = '0;
        logic [3:0]  bi;
        int          nfall = 0;
        int          nrise = 0;
        int          falls = 0;
        logic [15:0] cmds [$];

        assign miso[g] = miso_r;

        always @(negedge ss_n[g]) begin
            falls++;
            word   = {4'($urandom), adc_val[g][last_addr]};
            nfall  = 0;
            nrise  = 0;
            rxw    = '0;
            miso_r = word[15];
        end
        always @(negedge sclk[g]) if (ss_n[g] === 1'b0) begin
            nfall++;
            if (nfall >= 2 && nfall <= 16) begin
                bi     = 4'(16 - nfall);
                miso_r = word[bi];
            end
        end
        always @(posedge sclk[g]) if (ss_n[g] === 1'b0) begin
            rxw = {rxw[14:0], mosi[g]};
            nrise++;
        end
        always @(posedge ss_n[g]) if (nrise == 16) begin
            cmds.push_back(rxw);
            last_addr = rxw[13:11];
            nrise     = 0;
        end
    end

    function automatic int num_ch(input int g);
        return (g == 0) ? NumA : NumB;
    endfunction

    function automatic int sclk_div(input int g);
        return (g == 0) ? DivA : DivB;
    endfunction

    function automatic int chan_of(input int g, input int s);
        if (g == 1) return s;
        case (s)
            0:       return 0;
            1:       return 4;
            default: return 5;
        endcase
    endfunction

    function automatic logic [15:0] exp_cmd(input int g, input int t);
        int s;
        s = (t < num_ch(g)) ? t : num_ch(g) - 1;
        return {2'b00, 3'(chan_of(g, s)), 11'h000};
    endfunction

    function automatic logic [11:0] slot_val(input int g, input int s);
        if (g == 0) return res_a[12*s +: 12];
        return res_b[12*s +: 12];
    endfunction

    function automatic int get_falls(input int g);
        return (g == 0) ? gen_m[0].falls : gen_m[1].falls;
    endfunction

    function automatic int cmd_count(input int g);
        return (g == 0) ? gen_m[0].cmds.size() : gen_m[1].cmds.size();
    endfunction

    function automatic logic [15:0] pop_cmd(input int g);
        if (g == 0) begin
            if (gen_m[0].cmds.size() > 0) return gen_m[0].cmds.pop_front();
        end else begin
            if (gen_m[1].cmds.size() > 0) return gen_m[1].cmds.pop_front();
        end
        return 16'hFFFF;
    endfunction

    function automatic void flush(input int g);
        if (g == 0) gen_m[0].cmds.delete();
        else gen_m[1].cmds.delete();
    endfunction

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] expv);
        vecs++;
        assert (obs === expv) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic set_random(input int g);
        for (int c = 0; c < 8; c++) adc_val[g][c] = 12'($urandom);
    endtask

    task automatic model_reset();
        for (int g = 0; g < 2; g++) begin
            primed[g] = 1'b0;
            for (int s = 0; s < 8; s++) exp_res[g][s] = 0;
        end
    endtask

    // Slot s holds the reading of channel CH_MAP[s]; instance a averages with a 1/4 weight.
    task automatic model_sweep(input int g);
        for (int s = 0; s < num_ch(g); s++) begin
            int x;
            int r;
            x = int'(adc_val[g][chan_of(g, s)]);
            r = exp_res[g][s];
            if (g == 0 && primed[0]) exp_res[g][s] = r + ((x - r) >>> 2);
            else exp_res[g][s] = x;
        end
        primed[g] = 1'b1;
    endtask

    // Called on a negedge; with lock set, extra nxt pulses are issued mid-sweep and in DONE.
    task automatic run_sweep(input int g, input bit lock);
        int n;
        int f0;
        int lat_exp;
        bit seen;
        flush(g);
        f0   = get_falls(g);
        n    = 0;
        seen = 1'b0;
        nxt[g] = 1'b1;
        while (!seen && n < 6000) begin
            @(negedge clk);
            n++;
            nxt[g] = lock && (n == 100 || n == 1500);
            seen   = done[g];
        end
        nxt[g]  = lock;
        lat_exp = (num_ch(g) + 1) * (17 * sclk_div(g) + sclk_div(g) / 2) + 1;
        chk($sformatf("g%0d_latency", g), 96'(n), 96'(lat_exp));
        chk($sformatf("g%0d_busy_at_done", g), 96'(busy[g]), 96'(0));
        @(negedge clk);
        nxt[g] = 1'b0;
        chk($sformatf("g%0d_done_width", g), 96'(done[g]), 96'(0));
        chk($sformatf("g%0d_ss_falls", g), 96'(get_falls(g) - f0), 96'(num_ch(g) + 1));
        model_sweep(g);
        for (int s = 0; s < num_ch(g); s++)
            chk($sformatf("g%0d_slot%0d", g, s), 96'(slot_val(g, s)), 96'(exp_res[g][s]));
        chk($sformatf("g%0d_cmd_count", g), 96'(cmd_count(g)), 96'(num_ch(g) + 1));
        for (int t = 0; t <= num_ch(g); t++)
            chk($sformatf("g%0d_cmd%0d", g, t), 96'(pop_cmd(g)), 96'(exp_cmd(g, t)));
    endtask

    initial begin
        int f0;
        int nd;
        rst_n = 1'b0;
        nxt   = '0;
        for (int g = 0; g < 2; g++) for (int c = 0; c < 8; c++) adc_val[g][c] = '0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_ss_n", 96'(ss_n), 96'(2'b11));
        chk("rst_sclk", 96'(sclk), 96'(2'b11));
        chk("rst_mosi", 96'(mosi), 96'(2'b00));
        chk("rst_busy", 96'(busy), 96'(2'b00));
        chk("rst_done", 96'(done), 96'(2'b00));
        chk("rst_res_a", 96'(res_a), 96'(0));
        chk("rst_res_b", 96'(res_b), 96'(0));

        rst_n = 1'b1;
        f0 = get_falls(0) + get_falls(1);
        repeat (1000) @(negedge clk);
        chk("idle_no_ss", 96'(get_falls(0) + get_falls(1) - f0), 96'(0));
        chk("idle_ss_n", 96'(ss_n), 96'(2'b11));

        // Default traffic on instance a (first sweep after reset loads raw samples)
        adc_val[0][0] = 12'hABC;
        adc_val[0][4] = 12'h123;
        adc_val[0][5] = 12'hFFF;
        run_sweep(0, 1'b0);
        chk("default_results", 96'(res_a), 96'({12'hFFF, 12'h123, 12'hABC}));

        // Busy lockout, including nxt held during the DONE clk
        set_random(0);
        run_sweep(0, 1'b1);
        f0 = get_falls(0);
        nd = 0;
        repeat (100) begin
            @(negedge clk);
            if (done[0]) nd++;
        end
        chk("lockout_extra_done", 96'(nd), 96'(0));
        chk("lockout_extra_ss", 96'(get_falls(0) - f0), 96'(0));

        // Reset in the shift phase of transaction 2
        set_random(0);
        nxt[0] = 1'b1;
        @(negedge clk);
        nxt[0] = 1'b0;
        repeat (1299) @(negedge clk);
        chk("pre_rst_ss_n", 96'(ss_n[0]), 96'(0));
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_ss_n", 96'(ss_n[0]), 96'(1));
        chk("mid_rst_sclk", 96'(sclk[0]), 96'(1));
        chk("mid_rst_busy", 96'(busy[0]), 96'(0));
        chk("mid_rst_res", 96'(res_a), 96'(0));
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();

        // Raw reload after reset, then filter steps on slot 0
        set_random(0);
        adc_val[0][0] = 12'h000;
        run_sweep(0, 1'b0);
        set_random(0);
        adc_val[0][0] = 12'h400;
        run_sweep(0, 1'b0);
        chk("filt_step1", 96'(slot_val(0, 0)), 96'(12'h100));
        set_random(0);
        adc_val[0][0] = 12'h400;
        run_sweep(0, 1'b0);
        chk("filt_step2", 96'(slot_val(0, 0)), 96'(12'h1C0));
        set_random(0);
        adc_val[0][0] = 12'h000;
        run_sweep(0, 1'b0);
        chk("filt_down", 96'(slot_val(0, 0)), 96'(12'h150));

        // Eight channels, fast SCLK
        for (int c = 0; c < 8; c++) adc_val[1][c] = 12'(12'h100 * c);
        run_sweep(1, 1'b0);
        for (int s = 0; s < 8; s++)
            chk($sformatf("b_ramp_slot%0d", s), 96'(slot_val(1, s)), 96'(12'h100 * s));
        for (int k = 0; k < 3; k++) begin
            set_random(1);
            run_sweep(1, 1'b0);
        end

        for (int k = 0; k < 2; k++) begin
            set_random(0);
            run_sweep(0, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
